// File: rtl/fp_round_pkg.sv
// Shared constants for the fp_round_pipe rounding stage.
// Holds the rounding-mode encodings and the width of the optional statistics counters.
package fp_round_pkg;

    localparam logic [1:0] RND_HALF_UP = 2'b00;
    localparam logic [1:0] RND_RNE     = 2'b01;
    localparam logic [1:0] RND_TRUNC   = 2'b10;

    localparam int STATS_W = 16;

endpackage : fp_round_pkg

// File: rtl/fp_round_decide.sv
// Round-up decision for one beat: maps round/sticky/LSB and the rounding mode to
// an up flag and an inexact flag. Purely combinational.
module fp_round_decide
    import fp_round_pkg::*;
(
    input  logic       r_i,
    input  logic       s_i,
    input  logic       l_i,
    input  logic [1:0] mode_i,
    output logic       up_o,
    output logic       inexact_o
);

    // NOTE: the default assignment ahead of the case keeps every path driven, so no latch is inferred.
    always_comb begin
        up_o = 1'b0;
        case (mode_i)
            RND_HALF_UP: up_o = r_i;
            RND_RNE:     up_o = r_i & (s_i | l_i);
            RND_TRUNC:   up_o = 1'b0;
            default:     up_o = 1'b0;
        endcase
    end

    // Sticky is already the OR of every bit below the round bit.
    assign inexact_o = r_i | s_i;

endmodule : fp_round_decide

// File: rtl/fp_round_pipe.sv
// Two-stage rounding pipeline with valid/ready backpressure, exponent carry and saturation.
// Optional round-up/saturation counters are enabled with `define FP_ROUND_STATS_EN.
module fp_round_pipe
    import fp_round_pkg::*;
#(
    parameter int EXP_W  = 3,
    parameter int FRAC_W = 4,
    parameter int RB_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [FRAC_W-1:0] in_frac,
    input  logic [RB_W-1:0]   in_rbits,
    input  logic [1:0]        rnd_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_sat,
    output logic              out_inexact
`ifdef FP_ROUND_STATS_EN
    ,
    input  logic               stats_clr,
    output logic [STATS_W-1:0] cnt_up,
    output logic [STATS_W-1:0] cnt_sat
`endif
);

    localparam logic [FRAC_W-1:0] FRAC_ONE  = FRAC_W'(1);
    localparam logic [FRAC_W-1:0] FRAC_LEAD = FRAC_W'(1) << (FRAC_W - 1);
    localparam logic [EXP_W-1:0]  EXP_ONE   = EXP_W'(1);

    logic stall;
    logic sticky;
    logic up_d;
    logic inexact_d;

    logic              s1_valid_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [FRAC_W-1:0] s1_frac_q;
    logic              s1_up_q;
    logic              s1_inexact_q;

    logic              frac_max;
    logic              exp_max;
    logic [EXP_W-1:0]  exp_d;
    logic [FRAC_W-1:0] frac_d;
    logic              sat_d;

    logic              out_valid_q;
    logic [EXP_W-1:0]  out_exp_q;
    logic [FRAC_W-1:0] out_frac_q;
    logic              out_sat_q;
    logic              out_inexact_q;

    // A held result blocks both stages; nothing moves until downstream takes it.
    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = rst_n & ~stall;

    generate
        if (RB_W > 1) begin : g_sticky
            assign sticky = |in_rbits[RB_W-2:0];
        end else begin : g_no_sticky
            assign sticky = 1'b0;
        end
    endgenerate

    fp_round_decide u_decide (
        .r_i       (in_rbits[RB_W-1]),
        .s_i       (sticky),
        .l_i       (in_frac[0]),
        .mode_i    (rnd_mode),
        .up_o      (up_d),
        .inexact_o (inexact_d)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_exp_q     <= '0;
            s1_frac_q    <= '0;
            s1_up_q      <= 1'b0;
            s1_inexact_q <= 1'b0;
        end else if (!stall) begin
            s1_valid_q   <= in_valid;
            s1_exp_q     <= in_exp;
            s1_frac_q    <= in_frac;
            s1_up_q      <= up_d;
            s1_inexact_q <= inexact_d;
        end
    end

    assign frac_max = &s1_frac_q;
    assign exp_max  = &s1_exp_q;

    always_comb begin
        exp_d  = s1_exp_q;
        frac_d = s1_frac_q;
        sat_d  = 1'b0;
        if (s1_up_q) begin
            if (!frac_max) begin
                frac_d = s1_frac_q + FRAC_ONE;
            end else if (!exp_max) begin
                exp_d  = s1_exp_q + EXP_ONE;
                frac_d = FRAC_LEAD;
            end else begin
                sat_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_exp_q     <= '0;
            out_frac_q    <= '0;
            out_sat_q     <= 1'b0;
            out_inexact_q <= 1'b0;
        end else if (!stall) begin
            out_valid_q   <= s1_valid_q;
            out_exp_q     <= exp_d;
            out_frac_q    <= frac_d;
            out_sat_q     <= sat_d;
            out_inexact_q <= s1_inexact_q;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_exp     = out_exp_q;
    assign out_frac    = out_frac_q;
    assign out_sat     = out_sat_q;
    assign out_inexact = out_inexact_q;

`ifdef FP_ROUND_STATS_EN
    logic               rounded_d;
    logic               out_rounded_q;
    logic               out_xfer;
    logic [STATS_W-1:0] cnt_up_q;
    logic [STATS_W-1:0] cnt_sat_q;

    // A round-up that hits the maximum is held, so it is not counted as rounded.
    assign rounded_d = s1_up_q & ~(frac_max & exp_max);
    assign out_xfer  = out_valid_q & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_rounded_q <= 1'b0;
        end else if (!stall) begin
            out_rounded_q <= rounded_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            cnt_up_q  <= '0;
            cnt_sat_q <= '0;
        end else if (out_xfer) begin
            if (out_rounded_q && !(&cnt_up_q)) begin
                cnt_up_q <= cnt_up_q + STATS_W'(1);
            end
            if (out_sat_q && !(&cnt_sat_q)) begin
                cnt_sat_q <= cnt_sat_q + STATS_W'(1);
            end
        end
    end

    assign cnt_up  = cnt_up_q;
    assign cnt_sat = cnt_sat_q;
`endif

endmodule : fp_round_pipe

// File: doc/fp_round_pipe.md
# fp_round_pipe

Parametrised, pipelined rounding stage for the floating-point conversion datapath. It takes a normalised exponent/significand pair plus the discarded low-order bits and applies a run-time selectable rounding mode. It handles significand carry into the exponent and saturates at the largest representable value. It sits between the normaliser and the output register/display stage and adds a valid/ready handshake with backpressure, so it can be chained in streaming designs.

## Interface
- EXP_W, 3, exponent width
- FRAC_W, 4, significand width (MSB is the leading one for non-zero values)
- RB_W, 2, width of discarded bits; MSB is the round bit, the rest OR into sticky (RB_W >= 1)
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_exp  in  EXP_W  exponent
- in_frac  in  FRAC_W  significand
- in_rbits  in  RB_W  discarded bits
- rnd_mode  in  2  rounding mode, sampled with the beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_exp  out  EXP_W  rounded exponent
- out_frac  out  FRAC_W  rounded significand
- out_sat  out  1  round-up requested but value already at maximum
- out_inexact  out  1  in_rbits non-zero

## Operation
- Round bit R = in_rbits[RB_W-1]; sticky S = OR of in_rbits[RB_W-2:0] (0 when RB_W = 1); L = in_frac[0].
- Modes: 2'b00 HALF_UP, up = R. 2'b01 RNE, up = R & (S | L). 2'b10 TRUNC, up = 0. 2'b11 is reserved and behaves as TRUNC.
- When up = 1 and in_frac != all-ones: out_frac = in_frac + 1, exponent unchanged.
- When up = 1, in_frac is all-ones and in_exp != all-ones: out_exp = in_exp + 1 and out_frac = 1 << (FRAC_W-1).
- When up = 1 and both fields are all-ones: the value is held unchanged and out_sat = 1.
- When up = 0: pass-through. out_sat = 0.
- out_inexact = (in_rbits != 0) regardless of mode.
- All arithmetic is unsigned and modulo field width. No intermediate wider than FRAC_W+1.

## Timing
- Two-stage pipeline.
  - S1 registers the fields, mode, up and inexact.
  - S2 registers the final result.
- Latency is 2 cycles from accepted input to out_valid when there is no stall.
- Throughput is 1 beat per cycle.
- Transfer occurs on valid & ready at a rising edge.
- stall = out_valid & ~out_ready. While stall is high, both stages hold their contents.
- in_ready = rst_n & ~stall, combinational.
- A bubble in S1 propagates normally. A downstream stall never drops or duplicates a beat.
- While stalled, out_* remain stable until accepted.
- Reset values:
  - out_valid = 0, out_exp = 0, out_frac = 0, out_sat = 0, out_inexact = 0.
  - S1 valid = 0.
- Reset mid-stream discards all in-flight beats on the reset edge.
- in_valid with in_ready = 0 has no effect. The source must hold the beat.

## Configuration
- FP_ROUND_STATS_EN defined: adds input stats_clr and outputs cnt_up[15:0] and cnt_sat[15:0].
  - cnt_up increments on each output transfer with a round-up applied, including exponent carry.
  - cnt_sat increments on each output transfer with out_sat = 1.
  - Both counters saturate at 16'hFFFF.
  - Both are cleared by reset or by stats_clr; stats_clr wins over a same-cycle increment.
- Undefined: those ports and counters do not exist; datapath behaviour is identical.

## Structure
- Package fp_round_pkg holds:
  - localparams RND_HALF_UP = 2'b00, RND_RNE = 2'b01, RND_TRUNC = 2'b10
  - counter width constant STATS_W = 16
- Sub-module fp_round_decide: combinational {R, S, L, mode} -> {up, inexact}, instantiated in S1.
- Carry and saturation logic, pipeline registers and handshake live in the top module.

## Test plan
- Default widths, HALF_UP, exp=3'b010, frac=4'b1011, rbits=2'b10 -> after 2 cycles exp=010, frac=1100, sat=0, inexact=1.
- RNE tie handling:
  - frac=4'b1010, rbits=2'b10 -> frac=1010 (even, no round).
  - frac=4'b1011, rbits=2'b10 -> frac=1100.
  - frac=4'b1010, rbits=2'b11 -> frac=1011.
- Carry: HALF_UP, exp=3'b011, frac=4'b1111, rbits=2'b10 -> exp=100, frac=1000, sat=0.
- Saturation: HALF_UP, exp=3'b111, frac=4'b1111, rbits=2'b11 -> exp=111, frac=1111, sat=1. TRUNC with the same input -> sat=0, inexact=1.
- Backpressure:
  - Stream 6 back-to-back beats and hold out_ready=0 for 3 cycles mid-stream -> in_ready falls the cycle stall asserts; outputs stay stable; all 6 results arrive in order with no loss or duplication.
  - Assert rst_n=0 for one cycle mid-stream -> out_valid=0 next cycle; no stale beat emerges afterwards.
- With FP_ROUND_STATS_EN: 3 round-up beats and 1 saturating beat -> cnt_up=3 (the saturating beat is held, not rounded), cnt_sat=1. stats_clr -> both 0 next cycle.
